// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: 4-digit BCD event counter with time-multiplexed digit scanner; LEADING_ZERO_BLANK_EN builds leading-zero blanking.
// Latency: count 1 cycle after inc/clr, display 1 cycle behind count; no backpressure, every inc is accepted.
module bcd_scan_counter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [3:0]  bcd_out,
  output logic        leading_zero,
  output logic [3:0]  digit_sel,
  output logic [15:0] count_bcd,
  output logic        overflow
);

  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  logic [3:0]    d [4];
  logic [4:0]    carry;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          slot_end;

  // carry[k] is the increment arriving at digit k; carry[4] marks the 9999 wrap
  always_comb begin
    carry[0] = inc;
    for (int k = 0; k < 4; k++) begin
      carry[k+1] = carry[k] && (d[k] == 4'd9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) d[k] <= 4'd0;
      overflow <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < 4; k++) d[k] <= 4'd0;
      overflow <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (carry[k]) d[k] <= (d[k] == 4'd9) ? 4'd0 : d[k] + 4'd1;
      end
      overflow <= carry[4];
    end
  end

  assign count_bcd = {d[3], d[2], d[1], d[0]};

  assign slot_end = (presc == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz_vec;

  // digit k is blank-eligible only when it and every more significant digit is zero
  always_comb begin
    lz_vec[0] = 1'b0;
    lz_vec[3] = (d[3] == 4'd0);
    lz_vec[2] = lz_vec[3] && (d[2] == 4'd0);
    lz_vec[1] = lz_vec[2] && (d[1] == 4'd0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel    <= 4'b1110;
      bcd_out      <= 4'd0;
      leading_zero <= 1'b0;
    end else begin
      digit_sel <= ~(4'b0001 << idx);
      bcd_out   <= d[idx];
`ifdef LEADING_ZERO_BLANK_EN
      leading_zero <= lz_vec[idx];
`else
      leading_zero <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter with SCAN_DIV=4; expectations are tagged with the cycle they apply to.
module tb_bcd_scan_counter;

  localparam int SD = 4;
  localparam int S_CNT  = 0;
  localparam int S_OVF  = 1;
  localparam int S_DSEL = 2;
  localparam int S_BCD  = 3;
  localparam int S_LZ   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  bcd_out;
  logic        leading_zero;
  logic [3:0]  digit_sel;
  logic [15:0] count_bcd;
  logic        overflow;

  bcd_scan_counter #(.SCAN_DIV(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (inc),
    .clr          (clr),
    .bcd_out      (bcd_out),
    .leading_zero (leading_zero),
    .digit_sel    (digit_sel),
    .count_bcd    (count_bcd),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // cyc = number of rising edges since the last reset release
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  function automatic logic [15:0] sample(input int sel);
    case (sel)
      S_CNT:   return count_bcd;
      S_OVF:   return {15'h0, overflow};
      S_DSEL:  return {12'h0, digit_sel};
      S_BCD:   return {12'h0, bcd_out};
      default: return {15'h0, leading_zero};
    endcase
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int sel, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    e.name = n;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL %s: check for cyc %0d missed, now cyc %0d", mon_e.name, mon_e.cyc, cyc);
        end else begin
          compare(mon_e.name, sample(mon_e.sel), mon_e.val);
        end
      end
    end
  end

  // One check per scan slot, taken in the second cycle of each slot.
  task automatic check_display(input logic [15:0] val, input logic [3:0] lz);
    int         start;
    int         k;
    logic [3:0] sel;
    logic [3:0] lze;
    start = cyc + 2;
`ifdef LEADING_ZERO_BLANK_EN
    lze = lz;
`else
    lze = 4'b0000;
`endif
    for (int c = start; c < start + 16; c++) begin
      if ((c - 1) % SD == 1) begin
        k = ((c - 1) / SD) % 4;
        sel = ~(4'b0001 << k);
        push(c, S_DSEL, {12'h0, sel}, $sformatf("digit_sel slot%0d", k));
        push(c, S_BCD, {12'h0, val[4*k +: 4]}, $sformatf("bcd_out slot%0d", k));
        push(c, S_LZ, {15'h0, lze[k]}, $sformatf("leading_zero slot%0d", k));
      end
    end
    repeat (17) @(posedge clk);
    #1;
  endtask

  task automatic run_inc(input int n);
    inc = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    inc = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, S_CNT, 16'h0000, "reset count_bcd");
    push(0, S_OVF, 16'h0000, "reset overflow");
    push(0, S_DSEL, 16'h000E, "reset digit_sel");
    push(0, S_BCD, 16'h0000, "reset bcd_out");
    push(0, S_LZ, 16'h0000, "reset leading_zero");
    check_display(16'h0000, 4'b1110);

    for (int i = 0; i < 12; i++) begin
      inc = 1'b1;
      @(posedge clk);
      #1;
      inc = 1'b0;
      @(posedge clk);
      #1;
    end
    push(cyc, S_CNT, 16'h0012, "count after 12 pulses");
    check_display(16'h0012, 4'b1100);

    run_inc(9987);
    push(cyc, S_CNT, 16'h9999, "count preload 9999");
    push(cyc, S_OVF, 16'h0000, "overflow low at 9999");
    check_display(16'h9999, 4'b0000);
    inc = 1'b1;
    @(posedge clk);
    #1;
    inc = 1'b0;
    push(cyc, S_CNT, 16'h0000, "count wrap");
    push(cyc, S_OVF, 16'h0001, "overflow pulse");
    push(cyc + 1, S_OVF, 16'h0000, "overflow one cycle");
    push(cyc + 1, S_CNT, 16'h0000, "count after wrap");
    @(posedge clk);
    #1;

    inc = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    clr = 1'b1;
    push(cyc, S_CNT, 16'h0099, "count 0099");
    @(posedge clk);
    #1;
    clr = 1'b0;
    inc = 1'b0;
    push(cyc, S_CNT, 16'h0000, "clr+inc count");
    push(cyc, S_OVF, 16'h0000, "clr+inc overflow");

    run_inc(9999);
    push(cyc, S_CNT, 16'h9999, "count 9999 before clr");
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    push(cyc, S_CNT, 16'h0000, "clr at 9999 count");
    push(cyc, S_OVF, 16'h0000, "clr at 9999 overflow");

    run_inc(345);
    push(cyc, S_CNT, 16'h0345, "count 0345");
    @(posedge clk);
    #1;
    guard = 0;
    while (!(((cyc - 1) % SD == 1) && (((cyc - 1) / SD) % 4 == 2)) && guard < 32) begin
      @(posedge clk);
      #1;
      guard++;
    end
    push(cyc, S_DSEL, 16'h000B, "digit_sel before reset");
    push(cyc, S_BCD, 16'h0003, "bcd_out before reset");
    push(cyc, S_LZ, 16'h0000, "leading_zero before reset");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compare("async count_bcd", count_bcd, 16'h0000);
    compare("async overflow", {15'h0, overflow}, 16'h0000);
    compare("async digit_sel", {12'h0, digit_sel}, 16'h000E);
    compare("async bcd_out", {12'h0, bcd_out}, 16'h0000);
    compare("async leading_zero", {15'h0, leading_zero}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(1, S_CNT, 16'h0000, "count after release");
    push(1, S_DSEL, 16'h000E, "slot0 start after release");
    push(4, S_DSEL, 16'h000E, "slot0 end after release");
    push(5, S_DSEL, 16'h000D, "slot1 start after release");
    repeat (6) @(posedge clk);
    #1;

    run_inc(7);
    push(cyc, S_CNT, 16'h0007, "count 0007");
    check_display(16'h0007, 4'b1110);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
